// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants for the RISC-V softcore front end.
package fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Shift-register instruction FIFO: entry 0 is the registered head seen by decode.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  ent_q [DEPTH];
  fetch_entry_t  ent_d [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] wr_idx;

  // Write slot accounts for a same-cycle pop shifting everything down by one.
  always_comb begin
    ent_d   = ent_q;
    count_d = count_q;
    wr_idx  = count_q - CW'(pop);
    if (flush) begin
      count_d = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          ent_d[i] = ent_q[i+1];
        end
      end
      if (push) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (CW'(i) == wr_idx) ent_d[i] = push_data;
        end
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

  assign head  = ent_q[0];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited imem requests, buffers responses.
// Optional FETCH_MISALIGN_CHECK_EN halts fetch and raises misalign on a misaligned redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      op
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            misalign
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   fifo_count;
  logic [SW-1:0]   inflight;
  logic [XLEN-1:0] target;
  logic            halted;
  logic            gnt_fire;
  logic            push;
  logic            pop;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_data;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if (redirect && (redirect_pc[1:0] != 2'b00)) misalign_d = 1'b1;
  end

  // The sticky flag doubles as the halt state; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end

  assign halted   = misalign_q;
  assign misalign = misalign_q;
  assign target   = redirect_pc;
`else
  logic unused_redirect_lsb;

  assign halted              = 1'b0;
  assign target              = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

  // Credit check counts the slot freed by a same-cycle decode pop.
  always_comb begin
    inst_valid = (fifo_count != '0) && !redirect;
    pop        = inst_valid && inst_ready;
    inflight   = SW'(out_q) + SW'(fifo_count) - SW'(pop);
    imem_req   = rst_n && !redirect && !halted && (inflight < SW'(DEPTH));
    gnt_fire   = imem_req && imem_gnt;
    push       = imem_rvalid && (drop_q == '0) && !redirect && !halted;
  end

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    out_d     = out_q + CW'(gnt_fire) - CW'(imem_rvalid);
    drop_d    = drop_q;
    if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (gnt_fire) pc_d = pc_q + XLEN'(PC_STEP);
    if (push)     resp_pc_d = resp_pc_q + XLEN'(PC_STEP);
    // Everything still in flight after this cycle belongs to the old path.
    if (redirect) begin
      pc_d      = target;
      resp_pc_d = target;
      drop_d    = out_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
    end
  end

  assign push_data.pc   = resp_pc_q;
  assign push_data.inst = imem_rdata;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign imem_addr = pc_q;
  assign inst      = fifo_head.inst;
  assign inst_pc   = fifo_head.pc;
  assign op        = fifo_head.inst[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected fetches, a monitor checks decode transfers.
module tb_fetch_unit;
  import fetch_pkg::*;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid, redirect, inst_valid, inst_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
  logic [6:0]  op;
  logic        imem_req_w, rvalid_w, inst_valid_w;
  logic [31:0] imem_addr_w, rdata_w, inst_w, inst_pc_w;
  logic [6:0]  op_w;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign, misalign_w;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          lat;
  logic        ready_v, gnt_v, redir_v;
  logic [31:0] redir_pc_v;
  logic [31:0] exp_addr;
  logic        fire_w;
  logic [31:0] addr_w;
  pend_t        pend[$];
  fetch_entry_t sb[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .op(op)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_gnt(1'b1), .imem_rvalid(rvalid_w), .imem_rdata(rdata_w),
    .redirect(1'b0), .redirect_pc(32'h0), .inst_valid(inst_valid_w),
    .inst_ready(1'b1), .inst(inst_w), .inst_pc(inst_pc_w), .op(op_w)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .misalign(misalign_w)
`endif
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    logic [6:0] o;
    case (a[3:2])
      2'd0:    o = OP_LOAD;
      2'd1:    o = OP_STORE;
      2'd2:    o = OP_RTYPE;
      default: o = OP_BRANCH;
    endcase
    return {a[26:2], o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs and memory at negedge, record grants once settled.
  task automatic step();
    @(negedge clk);
    cyc++;
    inst_ready  = ready_v;
    imem_gnt    = gnt_v;
    redirect    = redir_v;
    redirect_pc = redir_pc_v;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    rvalid_w = fire_w;
    rdata_w  = word(addr_w);
    #1;
    if (imem_req && imem_gnt) begin
      chk("imem_addr", imem_addr, exp_addr);
      pend.push_back('{addr: imem_addr, due: cyc + lat});
      sb.push_back('{pc: exp_addr, inst: word(exp_addr)});
      exp_addr = exp_addr + 32'd4;
    end
    if (redirect) begin
      sb.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
      exp_addr = redirect_pc;
`else
      exp_addr = {redirect_pc[31:2], 2'b00};
`endif
    end
    fire_w = rst_n && imem_req_w;
    addr_w = imem_addr_w;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_req_w", 32'(imem_req_w), 32'd0);
    chk("rst_valid_w", 32'(inst_valid_w), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_op", 32'(op), 32'd0);
    pend.delete();
    sb.delete();
    exp_addr    = 32'h0;
    fire_w      = 1'b0;
    addr_w      = 32'h0;
    imem_rvalid = 1'b0;
    rvalid_w    = 1'b0;
    redirect    = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc   = -1;
  endtask

  task automatic drain(input int n);
    gnt_v = 1'b0;
    repeat (n) step();
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_fifo_empty", 32'(inst_valid), 32'd0);
    gnt_v = 1'b1;
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redir_v    = 1'b1;
    redir_pc_v = tgt;
    step();
    redir_v = 1'b0;
  endtask

  // Monitor: every decode transfer must match the oldest expected fetch.
  initial begin
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && inst_valid && inst_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL xfer_unexpected: got pc %h expected none", inst_pc);
        end else begin
          e = sb.pop_front();
          chk("xfer_pc", inst_pc, e.pc);
          chk("xfer_inst", inst, e.inst);
          chk("xfer_op", 32'(op), 32'(e.inst[6:0]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; inst_ready = 1'b1; imem_gnt = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; rvalid_w = 1'b0; rdata_w = 32'h0;
    ready_v = 1'b1; gnt_v = 1'b1; redir_v = 1'b0; redir_pc_v = 32'h0; lat = 1;
    cyc = -1; exp_addr = 32'h0; fire_w = 1'b0; addr_w = 32'h0;
    do_reset();

    // Streaming, 1-cycle memory
    for (int c = 0; c < 12; c++) begin
      step();
      if (c == 0) begin
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);
      end
      if (c == 1) chk("no_valid_c1", 32'(inst_valid), 32'd0);
      if (c == 2) chk("first_inst_pc", inst_pc, 32'h0);
      if (c >= 2) chk("stream_valid", 32'(inst_valid), 32'd1);
    end

    // Decode backpressure
    ready_v = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_req", 32'(imem_req), 32'd0);
      chk("bp_valid", 32'(inst_valid), 32'd1);
      if (sb.size() > 0) begin
        chk("bp_pc", inst_pc, sb[0].pc);
        chk("bp_inst", inst, sb[0].inst);
      end else begin
        checks++;
        errors++;
        $display("FAIL bp_sb: got empty expected pending entry");
      end
    end
    ready_v = 1'b1;
    repeat (4) step();
    drain(5);

    // Redirect coincident with decode transfer and response
    repeat (4) step();
    do_redirect(32'h0000_0100);
    chk("redir_valid_R", 32'(inst_valid), 32'd0);
    chk("redir_req_R", 32'(imem_req), 32'd0);
    step();
    chk("redir_valid_R1", 32'(inst_valid), 32'd0);
    chk("redir_req_R1", 32'(imem_req), 32'd1);
    chk("redir_addr_R1", imem_addr, 32'h0000_0100);
    step();
    chk("redir_valid_R2", 32'(inst_valid), 32'd0);
    step();
    chk("redir_valid_R3", 32'(inst_valid), 32'd1);
    chk("redir_pc_R3", inst_pc, 32'h0000_0100);
    repeat (3) step();
    drain(5);

    // Redirect with a response still in flight (2-cycle memory)
    lat = 2;
    repeat (5) step();
    do_redirect(32'h0000_0200);
    for (int c = 1; c <= 3; c++) begin
      step();
      chk("drop_valid_low", 32'(inst_valid), 32'd0);
    end
    step();
    chk("drop_valid_R4", 32'(inst_valid), 32'd1);
    chk("drop_pc_R4", inst_pc, 32'h0000_0200);
    repeat (6) step();
    drain(7);

    // Misaligned redirect target
    lat = 1;
    repeat (4) step();
    do_redirect(32'h0000_0102);
    step();
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("misalign_set", 32'(misalign), 32'd1);
    chk("misalign_req", 32'(imem_req), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_valid", 32'(inst_valid), 32'd0);
    end
`else
    chk("align_req", 32'(imem_req), 32'd1);
    chk("align_addr", imem_addr, 32'h0000_0100);
    repeat (3) step();
    drain(5);
`endif

    // Mid-stream reset, then restart and PC wrap on the second instance
    repeat (3) step();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 0) begin
        chk("restart_addr", imem_addr, 32'h0);
        chk("wrap_req0", 32'(imem_req_w), 32'd1);
        chk("wrap_addr0", imem_addr_w, 32'hFFFF_FFF8);
      end
      if (c == 1) chk("wrap_addr1", imem_addr_w, 32'hFFFF_FFFC);
      if (c == 2) begin
        chk("wrap_addr2", imem_addr_w, 32'h0000_0000);
        chk("wrap_pc2", inst_pc_w, 32'hFFFF_FFF8);
        chk("restart_pc", inst_pc, 32'h0);
      end
      if (c == 3) chk("wrap_pc3", inst_pc_w, 32'hFFFF_FFFC);
      if (c == 4) begin
        chk("wrap_pc4", inst_pc_w, 32'h0000_0000);
        chk("wrap_inst4", inst_w, word(32'h0000_0000));
      end
    end
    drain(5);

    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
